// File: rtl/alu_op_issuer.sv
// alu_op_issuer: queues ALU commands (cmd_*), issues them on alu_a/alu_b/alu_op_sel, waits ALU_LAT cycles, returns alu_result on rsp_* (busy = work pending); define ALU_OP_ISSUER_CHECK_EN to flag result mismatches on rsp_err
module alu_op_issuer #(
  parameter int WIDTH      = 32,
  parameter int ALU_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [1:0]       rsp_op,
  output logic             rsp_err,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ptr_one = 1;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
  state_t state;
  logic [WIDTH-1:0] a_mem [FIFO_DEPTH];
  logic [WIDTH-1:0] b_mem [FIFO_DEPTH];
  logic [1:0] op_mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [3:0] cnt;
  logic [1:0] tag;
  logic empty, full, push, pop;
  logic [WIDTH-1:0] head_a, head_b;
  logic [1:0] head_op;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign cmd_ready = !full;
  assign push = cmd_valid && !full;
  assign pop = !empty && (state == IDLE || (state == HOLD && rsp_ready));
  assign busy = !empty || state != IDLE;
  assign head_a = a_mem[rp[AW-1:0]];
  assign head_b = b_mem[rp[AW-1:0]];
  assign head_op = op_mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wp[AW-1:0]] <= cmd_a;
      b_mem[wp[AW-1:0]] <= cmd_b;
      op_mem[wp[AW-1:0]] <= cmd_op;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      tag <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op_sel <= '0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_op <= '0;
    end else begin
      if (push) wp <= wp + ptr_one;
      if (pop) begin
        rp <= rp + ptr_one;
        alu_a <= head_a;
        alu_b <= head_b;
        alu_op_sel <= head_op;
        tag <= head_op;
        cnt <= 4'(ALU_LAT);
      end
      case (state)
        IDLE: if (!empty) state <= WAIT;
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            rsp_result <= alu_result;
            rsp_op <= tag;
            rsp_valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state <= empty ? IDLE : WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ALU_OP_ISSUER_CHECK_EN
  logic [WIDTH-1:0] head_exp, exp_r;
  always_comb begin
    head_exp = head_op == 2'b00 ? head_a + head_b :
               head_op == 2'b01 ? head_a - head_b :
               head_op == 2'b10 ? head_a & head_b : head_a | head_b;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (pop) exp_r <= head_exp;
      if (state == WAIT && cnt == 4'd0) rsp_err <= alu_result != exp_r;
      else if (state == HOLD && rsp_ready) rsp_err <= 1'b0;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: randomized and directed scoreboard bench for alu_op_issuer against a behavioural ALU model
module tb_alu_op_issuer;
  localparam int W = 32;
  localparam int LAT = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [W-1:0] cmd_a = '0, cmd_b = '0;
  logic [1:0] cmd_op = '0;
  logic [W-1:0] alu_a, alu_b, alu_result, rsp_result;
  logic [1:0] alu_op_sel, rsp_op;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic inj = 1'b0;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  logic done = 1'b0;
  typedef struct {logic [W-1:0] r; logic [1:0] op; logic err;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_op_issuer #(.WIDTH(W), .ALU_LAT(LAT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op_sel(alu_op_sel), .alu_result(alu_result), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_op(rsp_op),
    .rsp_err(rsp_err), .busy(busy)
  );
  function automatic logic [W-1:0] model(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    return op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : a | b;
  endfunction
  logic [W-1:0] alu_comb;
  assign alu_comb = model(alu_op_sel, alu_a, alu_b) ^ {{(W-1){1'b0}}, inj && alu_op_sel == 2'd0};
  if (LAT == 0) begin : g_comb
    assign alu_result = alu_comb;
  end else begin : g_reg
    always @(posedge clk) alu_result <= alu_comb;
  end
  task automatic chk(string n, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got %h expected no response", rsp_result);
      end else begin
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.r);
        chk("rsp_op", {30'd0, rsp_op}, {30'd0, e.op});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end
  task automatic send(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    int t;
    logic e;
    exp_t x;
    t = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
`ifdef ALU_OP_ISSUER_CHECK_EN
    e = inj && op == 2'd0;
`else
    e = 1'b0;
`endif
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: cmd_ready got 0 expected 1");
    end else begin
      x.r = model(op, a, b) ^ {{(W-1){1'b0}}, inj && op == 2'd0};
      x.op = op;
      x.err = e;
      sb.push_back(x);
    end
    @(posedge clk);
    #1 acc_cyc = cyc;
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || sb.size() != 0) && t < 500);
    if (busy || sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: busy %0d pending %0d expected 0 0", busy, sb.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic set_rdy(logic v);
    @(posedge clk);
    #1 rsp_ready = v;
  endtask
  function automatic logic [W-1:0] rnd_val();
    int k;
    k = $urandom_range(0, 4);
    return k == 0 ? '0 : k == 1 ? '1 : k == 2 ? 32'h8000_0000 : $urandom;
  endfunction
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] r0, a0, b0;
    logic [1:0] o0;
    int t;
    repeat (2) @(negedge clk);
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_alu_op_sel", {30'd0, alu_op_sel}, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_op", {30'd0, rsp_op}, 0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("reset_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(2'd0, 32'h0A0A_0A0A, 32'h0505_0505);
    cmd_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 20);
    chk("latency", cyc - acc_cyc, LAT + 2);
    chk("add_result", rsp_result, 32'h0F0F_0F0F);
    set_rdy(1'b1);
    wait_idle();
    rsp_ready = 1'b0;
    send(2'd1, 32'h1F1F_1F1F, 32'h0F0F_0F0F);
    send(2'd2, 32'hFF00_FF00, 32'h00FF_00FF);
    send(2'd3, 32'hAA00_AA00, 32'h00FF_00FF);
    send(2'd0, 32'hFFFF_FFFF, 32'h1);
    send(2'd1, 32'h0, 32'h1);
    cmd_a = 32'h1234_5678;
    cmd_b = 32'h1;
    cmd_op = 2'd0;
    @(negedge clk);
    chk("full_cmd_ready", {31'd0, cmd_ready}, 0);
    chk("full_busy", {31'd0, busy}, 1);
    chk("hold_valid", {31'd0, rsp_valid}, 1);
    chk("hold_first", rsp_result, 32'h1010_1010);
    r0 = rsp_result;
    o0 = rsp_op;
    a0 = alu_a;
    b0 = alu_b;
    repeat (5) @(negedge clk);
    chk("bp_result", rsp_result, r0);
    chk("bp_op", {30'd0, rsp_op}, {30'd0, o0});
    chk("bp_alu_a", alu_a, a0);
    chk("bp_alu_b", alu_b, b0);
    chk("bp_no_pop", {31'd0, cmd_ready}, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    set_rdy(1'b1);
    wait_idle();
    send(2'd3, $urandom, $urandom);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstw_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rstw_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("rstw_busy", {31'd0, busy}, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rstw_no_stale", {31'd0, rsp_valid}, 0);
    set_rdy(1'b0);
    send(2'd0, $urandom, $urandom);
    cmd_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 20);
    rst_n = 1'b0;
    #1;
    chk("rsth_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rsth_busy", {31'd0, busy}, 0);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    set_rdy(1'b1);
    repeat (6) @(negedge clk);
    chk("rsth_no_stale", {31'd0, rsp_valid}, 0);
    @(posedge clk);
    #1;
`ifdef ALU_OP_ISSUER_CHECK_EN
    inj = 1'b1;
    send(2'd0, 32'h0000_1000, 32'h0000_0234);
    cmd_valid = 1'b0;
    wait_idle();
    inj = 1'b0;
    send(2'd0, 32'h0000_1000, 32'h0000_0234);
    cmd_valid = 1'b0;
    wait_idle();
`endif
    fork
      begin
        repeat (60) begin
          send(2'($urandom_range(0, 3)), rnd_val(), rnd_val());
          cmd_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 rsp_ready = ($urandom % 4) != 0;
        end
      end
    join
    rsp_ready = 1'b1;
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
